// File: rtl/div16by8_seq.sv
// div16by8_seq -- sequential restoring divider, 16-bit / 8-bit unsigned.
//
// Produces one quotient bit per clock. The operands are captured when start
// is accepted. Divide-by-zero and quotient overflow are caught in LOAD,
// before any iteration starts. The 3-bit state code matches the shift-add
// multiplier, so the same seven-segment display can show progress.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request, sampled on the rising edge
//   dividend   16-bit unsigned dividend, captured when start is accepted
//   divisor    8-bit unsigned divisor, captured when start is accepted
//   quotient   registered 8-bit quotient (8'hFF after an error)
//   remainder  registered 8-bit remainder (8'hFF after an error)
//   busy       high while in LOAD or CALC
//   done_flag  one-cycle pulse in DONE or ERR
//   div_zero   last operation had divisor == 0
//   overflow   last operation's quotient did not fit in 8 bits
//   state      FSM code: IDLE=0, LOAD=1, CALC=2, DONE=3, ERR=4
//
// Configuration macro: DIV_RESTART_EN. When it is defined, start in LOAD or
// CALC aborts the running operation and restarts with the new operands.
// When it is undefined, start is ignored while busy.

module div16by8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        done_flag,
  output logic        div_zero,
  output logic        overflow,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } fsm_t;

  fsm_t        fsm;
  logic [15:0] dvd;     // captured dividend
  logic [7:0]  dvs;     // captured divisor
  logic [8:0]  r;       // partial remainder; stays below dvs
  logic [7:0]  q;       // dividend low byte shifting out, quotient bits in
  logic [2:0]  cnt;     // CALC step index, 0..7

  logic [8:0]  t;
  logic [8:0]  r_step;
  logic [7:0]  q_step;
  logic        accept;

  // One restoring step. r < dvs always holds, so t fits in 9 bits.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    t      = {r[7:0], q[7]};
    r_step = t;
    q_step = {q[6:0], 1'b0};
    if (t >= {1'b0, dvs}) begin
      r_step = t - {1'b0, dvs};
      q_step = {q[6:0], 1'b1};
    end
  end

`ifdef DIV_RESTART_EN
  // start is honoured in every state; in LOAD or CALC it aborts the run.
  assign accept = start;
`else
  assign accept = start && (fsm == IDLE || fsm == DONE || fsm == ERR);
`endif

  assign state = fsm;

  // NOTE: state registers use non-blocking assignments so that every
  // register samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      dvd       <= '0;
      dvs       <= '0;
      r         <= '0;
      q         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done_flag <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done_flag <= 1'b0;
      if (accept) begin
        dvd      <= dividend;
        dvs      <= divisor;
        div_zero <= 1'b0;
        overflow <= 1'b0;
        busy     <= 1'b1;
        fsm      <= LOAD;
      end else begin
        case (fsm)
          LOAD: begin
            if (dvs == 8'd0) begin
              div_zero  <= 1'b1;
              quotient  <= 8'hFF;
              remainder <= 8'hFF;
              done_flag <= 1'b1;
              busy      <= 1'b0;
              fsm       <= ERR;
            end else if (dvd[15:8] >= dvs) begin
              // The quotient would need more than 8 bits.
              overflow  <= 1'b1;
              quotient  <= 8'hFF;
              remainder <= 8'hFF;
              done_flag <= 1'b1;
              busy      <= 1'b0;
              fsm       <= ERR;
            end else begin
              r   <= {1'b0, dvd[15:8]};
              q   <= dvd[7:0];
              cnt <= 3'd0;
              fsm <= CALC;
            end
          end
          CALC: begin
            r   <= r_step;
            q   <= q_step;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              quotient  <= q_step;
              remainder <= r_step[7:0];
              done_flag <= 1'b1;
              busy      <= 1'b0;
              fsm       <= DONE;
            end
          end
          DONE, ERR: fsm <= IDLE;
          default:   fsm <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div16by8_seq.sv
// tb_div16by8_seq -- self-checking bench for div16by8_seq.
// Each accepted start pushes the expected result and the cycle when it is due
// into a queue. A monitor pops an entry on every done_flag and compares it.

module tb_div16by8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done_flag;
  logic        div_zero;
  logic        overflow;
  logic [2:0]  state;

  div16by8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done_flag (done_flag),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] quo;
    logic [7:0] rem;
    logic       dz;
    logic       ov;
    int         due;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: error cases first, then plain integer division.
  // accept is the edge at which start is taken.
  function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs, input int accept);
    exp_t e;
    e.dz = 1'b0;
    e.ov = 1'b0;
    if (dvs == 8'd0) begin
      e.dz = 1'b1;
    end else if ({8'd0, dvd[15:8]} >= {8'd0, dvs}) begin
      e.ov = 1'b1;
    end
    if (e.dz || e.ov) begin
      e.quo = 8'hFF;
      e.rem = 8'hFF;
      e.due = accept + 1;
    end else begin
      e.quo = 8'(dvd / {8'd0, dvs});
      e.rem = 8'(dvd % {8'd0, dvs});
      e.due = accept + 9;
    end
    return e;
  endfunction

  // Monitor: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && done_flag) begin
      check("done_width", {31'd0, prev_done}, 32'd0);
      if (expq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("latency",   cyc,                 e.due);
        check("quotient",  {24'd0, quotient},   {24'd0, e.quo});
        check("remainder", {24'd0, remainder},  {24'd0, e.rem});
        check("div_zero",  {31'd0, div_zero},   {31'd0, e.dz});
        check("overflow",  {31'd0, overflow},   {31'd0, e.ov});
      end
    end
    prev_done = done_flag;
  end

  // Drives a one-cycle start pulse and records the expectation.
  task automatic start_op(input logic [15:0] dvd, input logic [7:0] dvs, output int accept);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    accept   = cyc + 1;
    expq.push_back(model(dvd, dvs, accept));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (expq.size() == 0) break;
      @(negedge clk);
    end
    check("drain", expq.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_quotient"},  {24'd0, quotient},  32'd0);
    check({tag, "_remainder"}, {24'd0, remainder}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_done"},      {31'd0, done_flag}, 32'd0);
    check({tag, "_div_zero"},  {31'd0, div_zero},  32'd0);
    check({tag, "_overflow"},  {31'd0, overflow},  32'd0);
    check({tag, "_state"},     {29'd0, state},     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int k2;
    exp_t e;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic division.
    start_op(16'd1000, 8'd7, k);
    wait_drain(30);

    // Largest quotient that fits, then overflow.
    start_op(16'hFEFF, 8'hFF, k);
    wait_drain(30);
    start_op(16'hFFFF, 8'hFF, k);
    wait_drain(30);

    // Divide by zero, then a clean operation clears the flag.
    start_op(16'd1234, 8'd0, k);
    wait_drain(30);
    start_op(16'd100, 8'd10, k);
    wait_drain(30);

    // Reset in the middle of CALC (cnt = 4 during the cycle after edge k+5).
    start_op(16'd5000, 8'd50, k);
    while (cyc < k + 5) @(negedge clk);
    check("mid_calc_state", {29'd0, state}, 32'd2);
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    start_op(16'd5000, 8'd50, k);
    wait_drain(30);

    // start held high: three back-to-back operations, ten cycles apart.
    @(negedge clk);
    dividend = 16'd300;
    divisor  = 8'd3;
    start    = 1'b1;
    k        = cyc + 1;
    for (int i = 0; i < 3; i++) expq.push_back(model(16'd300, 8'd3, k + 10 * i));
    @(negedge clk);
    for (int n = 0; n < 30; n++) begin
      int j;
      logic [2:0] exp_state;
      j = n % 10;
      exp_state = (j == 0) ? 3'd1 : (j == 9) ? 3'd3 : 3'd2;
      check("hold_state", {29'd0, state}, {29'd0, exp_state});
      check("hold_busy", {31'd0, busy}, {31'd0, (exp_state != 3'd3)});
      if (n == 20) start = 1'b0;
      @(negedge clk);
    end
    wait_drain(30);

    // Second start while at cnt = 3.
    start_op(16'd900, 8'd9, k);
    while (cyc < k + 4) @(negedge clk);
    check("restart_state", {29'd0, state}, 32'd2);
    dividend = 16'd255;
    divisor  = 8'd16;
    start    = 1'b1;
    k2       = cyc + 1;
`ifdef DIV_RESTART_EN
    e = expq.pop_back();
    expq.push_back(model(16'd255, 8'd16, k2));
`endif
    @(negedge clk);
    start = 1'b0;
    wait_drain(30);
    repeat (12) @(negedge clk);

    check("final_queue", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
